// File: rtl/mips_trace_buffer.sv
// ============================================================================
// mips_trace_buffer
// ----------------------------------------------------------------------------
// Instruction trace capture for the multicycle MIPS core. Every time the core
// control FSM enters its DECODE state, the instruction register value is
// captured once into a first-word-fall-through FIFO. A debug/host port drains
// the FIFO with a valid/ready handshake. Free-running counters (cycles, captured
// instructions, dropped captures) support CPI analysis on the host side.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   DECODE_STATE  core FSM encoding of DECODE (IR is valid in this state)
//   CNT_W         width of the cycle and instruction counters
//
// Ports
//   i_clk            rising-edge clock shared with the core
//   i_reset          asynchronous active-high reset, clears all state
//   i_instruction    core IR output
//   i_state          core control FSM state
//   i_clear          synchronous clear of FIFO, counters and overflow flag
//   i_trace_ready    consumer accepts o_trace_data this cycle
//   o_trace_data     FIFO head (first-word-fall-through)
//   o_trace_valid    FIFO non-empty
//   o_full           occupancy == DEPTH
//   o_level          current occupancy (0..DEPTH)
//   o_overflow       sticky: a capture was dropped because the FIFO was full
//   o_cycle_count    clocks since reset/clear, saturating
//   o_instr_count    captures seen (including dropped ones), saturating
//   o_drop_count     captures dropped on full, saturating
// ============================================================================
module mips_trace_buffer #(
    parameter int         DEPTH        = 16,
    parameter logic [3:0] DECODE_STATE = 4'd1,
    parameter int         CNT_W        = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [31:0]            i_instruction,
    input  logic [3:0]             i_state,
    input  logic                   i_clear,
    input  logic                   i_trace_ready,
    output logic [31:0]            o_trace_data,
    output logic                   o_trace_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic [CNT_W-1:0]       o_cycle_count,
    output logic [CNT_W-1:0]       o_instr_count,
    output logic [15:0]            o_drop_count
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            LW         = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [3:0]       r_prev_state;
    logic [31:0]      r_head;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;
    logic [15:0]      r_drop_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_capture;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [LW-1:0]    w_level_after_pop;
    logic [LW-1:0]    w_level_next;
    logic [31:0]      w_head_next;

    // Edge-detect on DECODE: a core that sits in DECODE for several cycles
    // still yields exactly one trace entry.
    assign w_capture = (i_state == DECODE_STATE) && (r_prev_state != DECODE_STATE);

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);

    // Clear overrides any FIFO movement in the same cycle. A ready with an
    // empty FIFO never pops, even if a capture lands in that same cycle.
    assign w_pop  = !i_clear && !w_empty && i_trace_ready;

    // A full FIFO still accepts a capture when the head leaves in the same
    // cycle; only a capture into a full, non-draining FIFO is dropped.
    assign w_push = !i_clear && w_capture && (!w_full || w_pop);
    assign w_drop = !i_clear && w_capture && w_full && !w_pop;

    assign w_rd_ptr_inc      = r_rd_ptr + AW'(1);
    assign w_level_after_pop = r_level - LW'(w_pop);
    assign w_level_next      = w_level_after_pop + LW'(w_push);

    // The head register presents the oldest entry one cycle after it becomes
    // the oldest. When the FIFO drains to empty it keeps the last value, so
    // o_trace_data is stable while o_trace_valid is low.
    always_comb begin
        w_head_next = r_head;
        if (w_pop && (w_level_after_pop != '0)) begin
            // Another entry remains behind the one leaving; it was written
            // in an earlier cycle, so the array already holds it.
            w_head_next = r_mem[w_rd_ptr_inc];
        end else if (w_push && (w_level_after_pop == '0)) begin
            // FIFO is (or becomes) empty apart from the new word: bypass the
            // array so the word is visible on the very next cycle.
            w_head_next = i_instruction;
        end
    end

    // ------------------------------------------------------------------------
    // Storage array (no reset: contents are meaningless until written)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_instruction;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, head, flags and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            // Starting "already in DECODE" suppresses a spurious capture in
            // the first cycle after reset.
            r_prev_state  <= DECODE_STATE;
            r_head        <= '0;
            r_overflow    <= 1'b0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_drop_count  <= '0;
        end else begin
            // DECODE tracking continues through a clear so that a clear issued
            // while the core is in DECODE does not cause a late capture.
            r_prev_state <= i_state;

            if (i_clear) begin
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_level       <= '0;
                r_overflow    <= 1'b0;
                r_cycle_count <= '0;
                r_instr_count <= '0;
                r_drop_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
                r_level <= w_level_next;
                r_head  <= w_head_next;

                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_count != 16'hFFFF) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                end

                // Counters saturate at all-ones rather than wrap, so a long
                // run reads as "at least this many" instead of a small lie.
                if (r_cycle_count != '1) begin
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                end
                if (w_capture && (r_instr_count != '1)) begin
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_trace_data  = r_head;
    assign o_trace_valid = !w_empty;
    assign o_full        = w_full;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;
    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;
    assign o_drop_count  = r_drop_count;

endmodule
